// File: rtl/lutram_bist_ctrl.sv
// BIST sequencer for one single-port LUTRAM column: checks the power-up INIT
// contents, writes a selectable pattern, then reads back and verifies it.
module lutram_bist_ctrl #(
  parameter int unsigned               ADDR_W          = 6,
  parameter logic [(2**ADDR_W)-1:0]    INIT            = 64'h0123456789ABCDEF,
  parameter bit                        SKIP_INIT_CHECK = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        pattern_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_d_o,
  input  logic              ram_q_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W+1:0] err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              first_err_phase_o
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_INIT,
    S_WRITE,
    S_GAP,
    S_VERIFY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PAT_ZEROS,
    PAT_ONES,
    PAT_CHECKER,
    PAT_INV_INIT
  } pattern_t;

  state_t              state_q, state_d;
  pattern_t            pat_q, pat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic                d_q, d_d;
  logic [ADDR_W+1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_addr_q, first_addr_d;
  logic                first_phase_q, first_phase_d;

  logic                start_ok;
  logic                last_addr;
  logic                checking;
  logic                exp_bit;
  logic                mismatch;

  function automatic logic pattern_bit(input pattern_t pat, input logic [ADDR_W-1:0] a);
    logic b;
    case (pat)
      PAT_ZEROS:   b = 1'b0;
      PAT_ONES:    b = 1'b1;
      PAT_CHECKER: b = a[0];
      default:     b = ~INIT[a];
    endcase
    return b;
  endfunction

  assign start_ok  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_addr = (addr_q == LAST_ADDR);
  assign checking  = (state_q == S_CHK_INIT) || (state_q == S_VERIFY);
  assign exp_bit   = (state_q == S_CHK_INIT) ? INIT[addr_q] : pattern_bit(pat_q, addr_q);
  assign mismatch  = checking && (ram_q_i != exp_bit);

  // NOTE: every signal written here gets a default first, so no path through
  // the case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    addr_d        = addr_q;
    err_cnt_d     = err_cnt_q;
    first_addr_d  = first_addr_q;
    first_phase_d = first_phase_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          pat_d   = pattern_t'(pattern_i);
          addr_d  = '0;
          state_d = SKIP_INIT_CHECK ? S_WRITE : S_CHK_INIT;
        end
      end
      S_CHK_INIT: begin
        if (last_addr) begin
          state_d = S_WRITE;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (last_addr) begin
          state_d = S_GAP;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_VERIFY;
        addr_d  = '0;
      end
      S_VERIFY: begin
        if (last_addr) begin
          state_d = S_DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    // Write port is decoded from the next state so it leaves a flop cleanly;
    // on the start edge pat_d already carries the freshly latched pattern.
    we_d = (state_d == S_WRITE);
    d_d  = we_d ? pattern_bit(pat_d, addr_d) : 1'b0;

    if (start_ok) begin
      err_cnt_d     = '0;
      first_addr_d  = '0;
      first_phase_d = 1'b0;
    end else if (mismatch) begin
      if (err_cnt_q == '0) begin
        first_addr_d  = addr_q;
        first_phase_d = (state_q == S_VERIFY);
      end
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pat_q         <= PAT_ZEROS;
      addr_q        <= '0;
      we_q          <= 1'b0;
      d_q           <= 1'b0;
      err_cnt_q     <= '0;
      first_addr_q  <= '0;
      first_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      d_q           <= d_d;
      err_cnt_q     <= err_cnt_d;
      first_addr_q  <= first_addr_d;
      first_phase_q <= first_phase_d;
    end
  end

  assign ram_we_o          = we_q;
  assign ram_addr_o        = addr_q;
  assign ram_d_o           = d_q;
  assign busy_o            = (state_q == S_CHK_INIT) || (state_q == S_WRITE) ||
                             (state_q == S_GAP)      || (state_q == S_VERIFY);
  assign done_o            = (state_q == S_DONE);
  assign pass_o            = done_o && (err_cnt_q == '0);
  assign err_cnt_o         = err_cnt_q;
  assign first_err_addr_o  = first_addr_q;
  assign first_err_phase_o = first_phase_q;

endmodule

// File: tb/tb_lutram_bist_ctrl.sv
// Self-checking bench for lutram_bist_ctrl: two instances (with and without the
// INIT check) each driving a behavioural LUTRAM with injectable faults.
module tb_lutram_bist_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [63:0] INIT  = 64'h0123456789ABCDEF;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i     = 1'b1;
  logic [1:0] pattern_i = 2'd0;
  logic       m_start   = 1'b0;
  logic       s_start   = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Main instance (full sequence) and its LUTRAM model
  logic       m_we, m_d, m_q, m_busy, m_done, m_pass, m_phase;
  logic [5:0] m_addr, m_first;
  logic [7:0] m_err;
  logic [63:0] m_mem, m_load_val = '0;
  logic m_load = 1'b0, m_inv = 1'b0, m_stuck = 1'b0, m_force0 = 1'b0;

  // Skip instance (no INIT check) and its LUTRAM model
  logic       s_we, s_d, s_q, s_busy, s_done, s_pass, s_phase;
  logic [5:0] s_addr, s_first;
  logic [7:0] s_err;
  logic [63:0] s_mem, s_load_val = '0;
  logic s_load = 1'b0, s_inv = 1'b0, s_stuck = 1'b0, s_force0 = 1'b0;

  lutram_bist_ctrl #(.ADDR_W(6), .INIT(INIT), .SKIP_INIT_CHECK(1'b0)) u_main (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(m_start), .pattern_i(pattern_i),
    .ram_we_o(m_we), .ram_addr_o(m_addr), .ram_d_o(m_d), .ram_q_i(m_q),
    .busy_o(m_busy), .done_o(m_done), .pass_o(m_pass), .err_cnt_o(m_err),
    .first_err_addr_o(m_first), .first_err_phase_o(m_phase)
  );

  lutram_bist_ctrl #(.ADDR_W(6), .INIT(INIT), .SKIP_INIT_CHECK(1'b1)) u_skip (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(s_start), .pattern_i(pattern_i),
    .ram_we_o(s_we), .ram_addr_o(s_addr), .ram_d_o(s_d), .ram_q_i(s_q),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err),
    .first_err_addr_o(s_first), .first_err_phase_o(s_phase)
  );

  // LUTRAM models: synchronous write on the (optionally inverted) clock, async read
  always @(posedge clk_i or negedge clk_i) begin
    if (m_load) m_mem <= m_load_val;
    else if (m_we && (clk_i ^ m_inv)) m_mem[m_addr] <= (m_stuck && m_addr == 6'd63) ? 1'b0 : m_d;
  end
  assign m_q = m_force0 ? 1'b0 : m_mem[m_addr];

  always @(posedge clk_i or negedge clk_i) begin
    if (s_load) s_mem <= s_load_val;
    else if (s_we && (clk_i ^ s_inv)) s_mem[s_addr] <= (s_stuck && s_addr == 6'd63) ? 1'b0 : s_d;
  end
  assign s_q = s_force0 ? 1'b0 : s_mem[s_addr];

  // Views of whichever instance the current scenario drives
  logic       cur_sel = 1'b0;
  logic       cur_we, cur_d, cur_busy, cur_done, cur_pass, cur_phase;
  logic [5:0] cur_addr, cur_first;
  logic [7:0] cur_err;
  assign cur_we    = cur_sel ? s_we    : m_we;
  assign cur_d     = cur_sel ? s_d     : m_d;
  assign cur_busy  = cur_sel ? s_busy  : m_busy;
  assign cur_done  = cur_sel ? s_done  : m_done;
  assign cur_pass  = cur_sel ? s_pass  : m_pass;
  assign cur_phase = cur_sel ? s_phase : m_phase;
  assign cur_addr  = cur_sel ? s_addr  : m_addr;
  assign cur_first = cur_sel ? s_first : m_first;
  assign cur_err   = cur_sel ? s_err   : m_err;

  function automatic bit pat_bit(input logic [1:0] p, input int a);
    logic [63:0] init_v;
    init_v = INIT;
    case (p)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return a[0];
      default: return ~init_v[a];
    endcase
  endfunction

  task automatic load(input bit sel, input logic [63:0] val);
    @(negedge clk_i);
    if (sel) begin s_load_val = val; s_load = 1'b1; end
    else     begin m_load_val = val; m_load = 1'b1; end
    @(negedge clk_i);
    m_load = 1'b0;
    s_load = 1'b0;
  endtask

  // Run one full sequence and compare against the reference model
  task automatic run_seq(input bit sel, input logic [1:0] pat, input bit pulse_busy, input string name);
    logic [63:0] init_v, pre, post_exp, post;
    logic [5:0]  exp_addr;
    logic        exp_we, exp_d;
    bit          stuck, f0, rd, first_ph;
    int          nerr, first_a, busy_n, seq_bad, off, i;

    init_v = INIT;
    cur_sel = sel;
    pre   = sel ? s_mem : m_mem;
    stuck = sel ? s_stuck : m_stuck;
    f0    = sel ? s_force0 : m_force0;
    off   = sel ? 0 : DEPTH;

    nerr = 0; first_a = 0; first_ph = 1'b0;
    if (!sel) begin
      for (int a = 0; a < DEPTH; a++) begin
        rd = f0 ? 1'b0 : pre[a];
        if (rd != init_v[a]) begin
          if (nerr == 0) begin first_a = a; first_ph = 1'b0; end
          nerr++;
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) post_exp[a] = (stuck && a == 63) ? 1'b0 : pat_bit(pat, a);
    for (int a = 0; a < DEPTH; a++) begin
      rd = f0 ? 1'b0 : post_exp[a];
      if (rd != pat_bit(pat, a)) begin
        if (nerr == 0) begin first_a = a; first_ph = 1'b1; end
        nerr++;
      end
    end
    if (nerr > 255) nerr = 255;

    @(negedge clk_i);
    pattern_i = pat;
    if (sel) s_start = 1'b1; else m_start = 1'b1;
    @(negedge clk_i);
    m_start = 1'b0;
    s_start = 1'b0;

    busy_n = 0; seq_bad = 0;
    while (cur_busy && busy_n < 1000) begin
      i = busy_n;
      exp_d = 1'b0;
      if (!sel && i < DEPTH) begin
        exp_we = 1'b0; exp_addr = 6'(i);
      end else if (i < off + DEPTH) begin
        exp_we = 1'b1; exp_addr = 6'(i - off); exp_d = pat_bit(pat, i - off);
      end else if (i == off + DEPTH) begin
        exp_we = 1'b0; exp_addr = 6'd0;
      end else begin
        exp_we = 1'b0; exp_addr = 6'(i - off - DEPTH - 1);
      end
      if (cur_we !== exp_we || cur_addr !== exp_addr || (exp_we && cur_d !== exp_d)) seq_bad++;
      if (pulse_busy) begin
        pattern_i = 2'($urandom_range(0, 3));
        if (sel) s_start = 1'($urandom_range(0, 1)); else m_start = 1'($urandom_range(0, 1));
      end
      busy_n++;
      @(negedge clk_i);
    end
    m_start = 1'b0;
    s_start = 1'b0;
    post = sel ? s_mem : m_mem;

    checks++;
    if (busy_n !== off + 2 * DEPTH + 1) begin
      failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, off + 2 * DEPTH + 1);
    end
    checks++;
    if (seq_bad !== 0) begin
      failures++; $display("FAIL %s ram_port_sequence bad_cycles got=%0d exp=0", name, seq_bad);
    end
    checks++;
    if (cur_done !== 1'b1 || cur_busy !== 1'b0) begin
      failures++; $display("FAIL %s done_after_busy got done=%b busy=%b exp done=1 busy=0", name, cur_done, cur_busy);
    end
    checks++;
    if (cur_err !== 8'(nerr)) begin
      failures++; $display("FAIL %s err_cnt got=%0d exp=%0d", name, cur_err, nerr);
    end
    checks++;
    if (cur_pass !== (nerr == 0)) begin
      failures++; $display("FAIL %s pass got=%b exp=%b", name, cur_pass, (nerr == 0));
    end
    checks++;
    if (cur_first !== 6'(first_a) || cur_phase !== first_ph) begin
      failures++; $display("FAIL %s first_err got addr=%0d phase=%b exp addr=%0d phase=%b",
                           name, cur_first, cur_phase, first_a, first_ph);
    end
    checks++;
    if (post !== post_exp) begin
      failures++; $display("FAIL %s ram_contents got=%h exp=%h", name, post, post_exp);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    load(1'b0, INIT);
    load(1'b1, INIT);
    repeat (2) @(negedge clk_i);
    checks++;
    if ({m_we, m_addr, m_d, m_busy, m_done, m_pass, m_err, m_first, m_phase} !== '0 ||
        {s_we, s_addr, s_d, s_busy, s_done, s_pass, s_err, s_first, s_phase} !== '0) begin
      failures++; $display("FAIL reset_outputs got main_busy=%b main_err=%0d skip_busy=%b skip_err=%0d exp all 0",
                           m_busy, m_err, s_busy, s_err);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", m_busy, m_done);
    end
  endtask

  task automatic test_faults;
    logic [63:0] v;
    load(1'b0, INIT);
    run_seq(1'b0, 2'd1, 1'b0, "ones_default");
    v = INIT; v[5] = ~v[5];
    load(1'b0, v);
    run_seq(1'b0, 2'd2, 1'b0, "init_bit5_flip");
    checks++;
    if (m_err !== 8'd1 || m_first !== 6'd5 || m_phase !== 1'b0) begin
      failures++; $display("FAIL init_bit5_report got err=%0d addr=%0d phase=%b exp 1 5 0", m_err, m_first, m_phase);
    end
    load(1'b0, INIT);
    m_stuck = 1'b1;
    run_seq(1'b0, 2'd1, 1'b0, "stuck_addr63");
    m_stuck = 1'b0;
    checks++;
    if (m_err !== 8'd1 || m_first !== 6'd63 || m_phase !== 1'b1) begin
      failures++; $display("FAIL stuck63_report got err=%0d addr=%0d phase=%b exp 1 63 1", m_err, m_first, m_phase);
    end
  endtask

  task automatic test_inverted_clk;
    load(1'b0, INIT);
    m_inv = 1'b1;
    run_seq(1'b0, 2'd3, 1'b1, "inverted_clk_inv_init");
    m_inv = 1'b0;
    checks++;
    if (m_pass !== 1'b1) begin
      failures++; $display("FAIL inverted_clk_pass got=%b exp=1", m_pass);
    end
  endtask

  task automatic test_reset_mid_write;
    load(1'b0, INIT);
    @(negedge clk_i);
    pattern_i = 2'd1;
    m_start = 1'b1;
    @(negedge clk_i);
    m_start = 1'b0;
    repeat (DEPTH + 10) @(negedge clk_i);
    checks++;
    if (m_we !== 1'b1 || m_addr !== 6'd10) begin
      failures++; $display("FAIL mid_write_position got we=%b addr=%0d exp 1 10", m_we, m_addr);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({m_we, m_addr, m_d, m_busy, m_done, m_pass, m_err, m_first, m_phase} !== '0) begin
      failures++; $display("FAIL mid_write_reset got we=%b addr=%0d busy=%b done=%b exp all 0",
                           m_we, m_addr, m_busy, m_done);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (m_mem !== (INIT | 64'h7FF) || m_we !== 1'b0) begin
      failures++; $display("FAIL mid_write_contents got=%h exp=%h", m_mem, INIT | 64'h7FF);
    end
    run_seq(1'b0, 2'd1, 1'b1, "after_mid_reset");
  endtask

  task automatic test_skip_force0;
    load(1'b1, INIT);
    s_force0 = 1'b1;
    run_seq(1'b1, 2'd1, 1'b1, "skip_force0");
    s_force0 = 1'b0;
    checks++;
    if (s_err !== 8'd64 || s_first !== 6'd0 || s_phase !== 1'b1 || s_pass !== 1'b0) begin
      failures++; $display("FAIL skip_force0_report got err=%0d addr=%0d phase=%b pass=%b exp 64 0 1 0",
                           s_err, s_first, s_phase, s_pass);
    end
  endtask

  task automatic test_back_to_back;
    int held;
    load(1'b0, INIT);
    run_seq(1'b0, 2'd0, 1'b0, "b2b_first");
    held = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (m_done === 1'b1 && m_busy === 1'b0) held++;
    end
    checks++;
    if (held !== 5) begin
      failures++; $display("FAIL done_held got=%0d exp=5", held);
    end
    run_seq(1'b0, 2'd2, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_with_start;
    @(negedge clk_i);
    rst_i = 1'b1;
    m_start = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    m_start = 1'b0;
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_err !== 8'd0) begin
      failures++; $display("FAIL reset_beats_start got busy=%b done=%b err=%0d exp 0 0 0", m_busy, m_done, m_err);
    end
    @(negedge clk_i);
    checks++;
    if (m_busy !== 1'b0) begin
      failures++; $display("FAIL reset_beats_start_idle got busy=%b exp=0", m_busy);
    end
  endtask

  task automatic test_random;
    logic [63:0] mask;
    bit          sel;
    for (int n = 0; n < 8; n++) begin
      sel  = 1'($urandom_range(0, 1));
      mask = '0;
      repeat ($urandom_range(0, 3)) mask[$urandom_range(0, 63)] = 1'b1;
      load(sel, INIT ^ mask);
      if (sel) begin
        s_inv = 1'($urandom_range(0, 1)); s_stuck = ($urandom_range(0, 3) == 0); s_force0 = ($urandom_range(0, 7) == 0);
      end else begin
        m_inv = 1'($urandom_range(0, 1)); m_stuck = ($urandom_range(0, 3) == 0); m_force0 = ($urandom_range(0, 7) == 0);
      end
      run_seq(sel, 2'($urandom_range(0, 3)), 1'b1, "random");
      m_inv = 1'b0; m_stuck = 1'b0; m_force0 = 1'b0;
      s_inv = 1'b0; s_stuck = 1'b0; s_force0 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_faults();
    test_inverted_clk();
    test_reset_mid_write();
    test_skip_force0();
    test_back_to_back();
    test_reset_with_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lutram_bist_ctrl.md
Name: lutram_bist_ctrl

Overview:
- Built-in self-test sequencer for one single-port LUTRAM column (RAM64X1S / RAMS64E class: synchronous write, asynchronous read).
- Sequence: check the power-up INIT contents, write a selectable pattern to every address, then read back and verify.
- Reports pass/fail, saturating error count, and the first failing address and phase.
- Sits between the LUTRAM under test and the board-level status outputs in the LUTRAM characterisation top levels, including the clock-inversion variants.

Parameters:
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W.
- INIT, 64'h0123456789ABCDEF (width DEPTH), expected power-up contents; bit n = address n.
- SKIP_INIT_CHECK, 1'b0, 1 = omit the CHK_INIT phase (use after partial reconfiguration).

Ports:
- clk_i  in  1  sole clock; shared with the LUTRAM, whose own clock may be inverted.
- rst_i  in  1  synchronous reset, active-high.
- start_i  in  1  start pulse; sampled only in IDLE or DONE.
- pattern_i  in  2  write data select, latched at start: 0 = zeros, 1 = ones, 2 = checkerboard (addr[0]), 3 = ~INIT.
- ram_we_o  out  1  LUTRAM write enable.
- ram_addr_o  out  ADDR_W  LUTRAM address, shared by read and write.
- ram_d_o  out  1  LUTRAM write data.
- ram_q_i  in  1  LUTRAM asynchronous read data.
- busy_o  out  1  high in CHK_INIT, WRITE, GAP and VERIFY.
- done_o  out  1  high in DONE.
- pass_o  out  1  valid when done_o = 1; 1 iff err_cnt_o = 0.
- err_cnt_o  out  ADDR_W+2  saturating mismatch count.
- first_err_addr_o  out  ADDR_W  address of the first mismatch.
- first_err_phase_o  out  1  phase of the first mismatch: 0 = CHK_INIT, 1 = VERIFY.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst_i.
- Reset values: state = IDLE; all outputs 0, including ram_addr_o, ram_we_o, err_cnt_o and first_err_*.
- Reset mid-sequence: IDLE at the next edge; ram_we_o low from that edge; LUTRAM contents left as they are.
- States: IDLE, CHK_INIT, WRITE, GAP, VERIFY, DONE.
- IDLE/DONE + start_i:
  - clear err_cnt_o and first_err_*; latch pattern_i; addr = 0.
  - next state is CHK_INIT, or WRITE when SKIP_INIT_CHECK = 1.
- start_i while busy_o = 1 is ignored.
- Expected bit exp(a):
  - CHK_INIT: INIT[a].
  - WRITE/VERIFY: per the latched pattern (0, 1, a[0], ~INIT[a]).
- CHK_INIT:
  - ram_we_o = 0; ram_addr_o = addr.
  - Each cycle compare ram_q_i to exp(addr) combinationally; record the result at the edge.
  - addr increments each cycle; after addr = DEPTH-1, go to WRITE with addr = 0.
- WRITE:
  - ram_we_o = 1; ram_d_o = exp(addr); one address per cycle.
  - After DEPTH-1, go to GAP.
- GAP:
  - One cycle with ram_we_o = 0 and addr = 0.
  - Guarantees the last write completes when the LUTRAM clock is inverted (write lands on the falling edge).
- VERIFY: same as CHK_INIT but with the pattern expectation; after DEPTH-1, go to DONE.
- DONE: done_o held until reset or a new start_i.
- Mismatch handling:
  - err_cnt_o increments, saturating at all-ones.
  - first_err_addr_o and first_err_phase_o capture only when err_cnt_o = 0 before the increment.
- ram_we_o, ram_addr_o and ram_d_o are registered (decoded from next state), so they are glitch-free for the LUTRAM write port.
- Latency from the start edge:
  - busy_o high for 3*DEPTH+1 cycles (2*DEPTH+1 with SKIP_INIT_CHECK).
  - done_o rises in the cycle after busy_o falls.
  - DEPTH = 64: done_o at cycle 194 (130 with skip).
- Address wrap: addr never exceeds DEPTH-1; its increment is suppressed at the phase change.
- Simultaneous rst_i and start_i: reset wins.

Test Plan:
- Behavioural LUTRAM model, INIT default, pattern 1, start -> busy 193 cycles, done_o = 1, pass_o = 1, err_cnt_o = 0, model contents all ones.
- Model INIT bit 5 flipped, pattern 2 -> err_cnt_o = 1, first_err_addr_o = 5, first_err_phase_o = 0, pass_o = 0.
- Model write port stuck at 0 for address 63, pattern 1 -> err_cnt_o = 1, first_err_addr_o = 63, first_err_phase_o = 1.
- LUTRAM model clocked on inverted clk_i, pattern 3 -> pass_o = 1; the GAP cycle shows ram_we_o = 0.
- rst_i asserted 10 cycles into WRITE -> next cycle state IDLE, ram_we_o = 0, all outputs 0; a new start runs the full sequence correctly.
- Read data forced to 0, pattern 1, SKIP_INIT_CHECK = 1 -> err_cnt_o = 64, first_err_addr_o = 0, done_o at cycle 130; start_i pulses during busy are ignored.
